// File: rtl/detector_nota.sv
// Tone-period note detector: measures the rising-edge period of audio_in,
// classifies it against the player's note table and confirms stable notes.
module detector_nota #(
  parameter int PERIOD_W   = 20,
  parameter int TOL_SHIFT  = 6,
  parameter int STABLE_N   = 3,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 700000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                audio_in,
  output logic [3:0]          note,
  output logic                new_note,
  output logic                locked,
  output logic [PERIOD_W-1:0] period
);

  localparam int SW = $clog2(STABLE_N + 1);
  localparam logic [3:0] MUTE = 4'd11;
  localparam logic [3:0] UNK  = 4'd15;
  localparam logic [3:0] LAST = 4'd13;
  localparam logic [PERIOD_W-1:0] TO_CNT  = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_PERIOD);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_N);

  typedef enum logic {IDLE, MEAS} mstate_t;
  typedef enum logic [1:0] {C_IDLE, C_SEARCH, C_DONE} cstate_t;

  mstate_t mstate, mstate_n;
  cstate_t cstate, cstate_n;

  logic s1, s2, s3, rise;
  logic [PERIOD_W-1:0] cnt, cper, tab;
  logic [PERIOD_W:0]   ep, et, diff, tol;
  logic [3:0]          idx, result, prev_result;
  logic [SW-1:0]       stable, stable_nx;
  logic accept, drop, tmo, hit, confirm;

  function automatic logic [PERIOD_W-1:0] table_period(input logic [3:0] i);
    case (i)
      4'd0:    table_period = PERIOD_W'(191110);
      4'd1:    table_period = PERIOD_W'(95557);
      4'd2:    table_period = PERIOD_W'(143172);
      4'd3:    table_period = PERIOD_W'(227273);
      4'd4:    table_period = PERIOD_W'(113636);
      4'd5:    table_period = PERIOD_W'(151685);
      4'd6:    table_period = PERIOD_W'(170265);
      4'd7:    table_period = PERIOD_W'(180388);
      4'd8:    table_period = PERIOD_W'(90192);
      4'd9:    table_period = PERIOD_W'(107259);
      4'd10:   table_period = PERIOD_W'(127551);
      4'd12:   table_period = PERIOD_W'(340530);
      4'd13:   table_period = PERIOD_W'(85131);
      default: table_period = '0;
    endcase
  endfunction

  assign rise = s2 & ~s3;

  always_comb begin
    accept   = (mstate == MEAS) && rise && (cstate == C_IDLE);
    drop     = (mstate == MEAS) && rise && (cstate != C_IDLE);
    tmo      = (mstate == MEAS) && !rise && (cnt == TO_CNT);
    tab      = table_period(idx);
    ep       = {1'b0, cper};
    et       = {1'b0, tab};
    diff     = (ep >= et) ? (ep - et) : (et - ep);
    tol      = et >> TOL_SHIFT;
    hit      = (diff <= tol);
    // a zero count means no streak yet, so the first result always starts at 1
    if ((stable != '0) && (result == prev_result))
      stable_nx = (stable == STABLE_MAX) ? stable : stable + SW'(1);
    else
      stable_nx = SW'(1);
    confirm  = (stable_nx == STABLE_MAX);

    mstate_n = mstate;
    case (mstate)
      IDLE:    if (rise) mstate_n = MEAS;
      MEAS:    if (tmo)  mstate_n = IDLE;
      default: mstate_n = IDLE;
    endcase

    cstate_n = cstate;
    case (cstate)
      C_IDLE:   if (accept) cstate_n = (cnt < MIN_CNT) ? C_DONE : C_SEARCH;
      C_SEARCH: if (hit || (idx == LAST)) cstate_n = C_DONE;
      C_DONE:   cstate_n = C_IDLE;
      default:  cstate_n = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      mstate <= IDLE;
      cstate <= C_IDLE;
    end else begin
      s1 <= audio_in;
      s2 <= s1;
      s3 <= s2;
      mstate <= mstate_n;
      cstate <= cstate_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cper        <= '0;
      period      <= '0;
      idx         <= '0;
      result      <= UNK;
      prev_result <= UNK;
      stable      <= '0;
      note        <= MUTE;
      new_note    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      new_note <= 1'b0;

      if (mstate == IDLE)
        cnt <= rise ? PERIOD_W'(1) : '0;
      else if (rise)
        cnt <= PERIOD_W'(1);
      else if (tmo)
        cnt <= '0;
      else
        cnt <= cnt + PERIOD_W'(1);

      if (accept) begin
        period <= cnt;
        cper   <= cnt;
        idx    <= '0;
        if (cnt < MIN_CNT) result <= UNK;
      end

      if (cstate == C_SEARCH) begin
        if (hit)
          result <= idx;
        else if (idx == LAST)
          result <= UNK;
        else
          idx <= (idx == 4'd10) ? 4'd12 : idx + 4'd1;
      end

      if (cstate == C_DONE) begin
        prev_result <= result;
        stable      <= stable_nx;
        if (confirm && (result != note)) begin
          note     <= result;
          new_note <= 1'b1;
        end
        locked <= confirm;
      end

      if (drop) stable <= '0;

      if (tmo) begin
        stable   <= '0;
        locked   <= 1'b0;
        note     <= MUTE;
        new_note <= (note != MUTE);
      end
    end
  end

endmodule
